// File: rtl/controlador_estoque.sv
`default_nettype none
// ============================================================================
// Module      : controlador_estoque
// Description : Vending slot table with a 3-state command controller.
//               Commands: QUERY / VEND / WRITE / RESTOCK.
// Revision    : 1.0 - initial release
// ============================================================================
module controlador_estoque #(
    parameter int CODE_W    = 4,
    parameter int NUM_SLOTS = 16,
    parameter int PRICE_W   = 4,
    parameter int STOCK_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [CODE_W-1:0]    cmd_code,
    input  logic [PRICE_W-1:0]   cmd_price,
    input  logic [STOCK_W-1:0]   cmd_qty,
    output logic                 rsp_valid,
    output logic [1:0]           rsp_status,
    output logic [PRICE_W-1:0]   rsp_price,
    output logic                 rsp_exists,
    output logic [STOCK_W-1:0]   rsp_stock,
    output logic [NUM_SLOTS-1:0] sold_out
);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_EXEC = 2'd1;
    localparam logic [1:0] c_S_RESP = 2'd2;

    localparam logic [1:0] c_OP_QUERY   = 2'b00;
    localparam logic [1:0] c_OP_VEND    = 2'b01;
    localparam logic [1:0] c_OP_WRITE   = 2'b10;
    localparam logic [1:0] c_OP_RESTOCK = 2'b11;

    localparam logic [1:0] c_ST_OK       = 2'b00;
    localparam logic [1:0] c_ST_NO_PROD  = 2'b01;
    localparam logic [1:0] c_ST_SOLD_OUT = 2'b10;
    localparam logic [1:0] c_ST_OVERFLOW = 2'b11;

    localparam logic [STOCK_W-1:0] c_STOCK_MAX = '1;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               w_accept;

    logic [1:0]         r_op;
    logic [CODE_W-1:0]  r_code;
    logic [PRICE_W-1:0] r_price;
    logic [STOCK_W-1:0] r_qty;

    logic               r_exists    [NUM_SLOTS];
    logic [PRICE_W-1:0] r_price_tab [NUM_SLOTS];
    logic [STOCK_W-1:0] r_stock_tab [NUM_SLOTS];

    logic               w_hit;
    logic               w_cur_exists;
    logic [PRICE_W-1:0] w_cur_price;
    logic [STOCK_W-1:0] w_cur_stock;
    logic [STOCK_W:0]   w_sum;

    logic               w_wr;
    logic [1:0]         w_status;
    logic               w_new_exists;
    logic [PRICE_W-1:0] w_new_price;
    logic [STOCK_W-1:0] w_new_stock;

    assign w_accept = cmd_valid && cmd_ready;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: if (cmd_valid) w_state_nxt = c_S_EXEC;
            c_S_EXEC: w_state_nxt = c_S_RESP;
            c_S_RESP: w_state_nxt = c_S_IDLE;
            default:  w_state_nxt = c_S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        cmd_ready = (r_state == c_S_IDLE);
        rsp_valid = (r_state == c_S_RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op    <= '0;
            r_code  <= '0;
            r_price <= '0;
            r_qty   <= '0;
        end else if (w_accept) begin
            r_op    <= cmd_op;
            r_code  <= cmd_code;
            r_price <= cmd_price;
            r_qty   <= cmd_qty;
        end
    end

    // Codes beyond the table never match, so they read back as an all-zero slot.
    always_comb begin
        w_hit        = 1'b0;
        w_cur_exists = 1'b0;
        w_cur_price  = '0;
        w_cur_stock  = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (r_code == CODE_W'(i)) begin
                w_hit        = 1'b1;
                w_cur_exists = r_exists[i];
                w_cur_price  = r_price_tab[i];
                w_cur_stock  = r_stock_tab[i];
            end
        end
    end

    assign w_sum = {1'b0, w_cur_stock} + {1'b0, r_qty};

    always_comb begin
        w_wr         = 1'b0;
        w_status     = c_ST_OK;
        w_new_exists = w_cur_exists;
        w_new_price  = w_cur_price;
        w_new_stock  = w_cur_stock;
        if (!w_hit) begin
            w_status = c_ST_NO_PROD;
        end else begin
            case (r_op)
                c_OP_QUERY: begin
                    if (!w_cur_exists)          w_status = c_ST_NO_PROD;
                    else if (w_cur_stock == '0) w_status = c_ST_SOLD_OUT;
                end
                c_OP_VEND: begin
                    if (!w_cur_exists)          w_status = c_ST_NO_PROD;
                    else if (w_cur_stock == '0) w_status = c_ST_SOLD_OUT;
                    else begin
                        w_wr        = 1'b1;
                        w_new_stock = w_cur_stock - 1'b1;
                    end
                end
                c_OP_WRITE: begin
                    w_wr = 1'b1;
                    if (r_price != '0) begin
                        w_new_exists = 1'b1;
                        w_new_price  = r_price;
                        w_new_stock  = r_qty;
                    end else begin
                        w_status     = c_ST_NO_PROD;
                        w_new_exists = 1'b0;
                        w_new_price  = '0;
                        w_new_stock  = '0;
                    end
                end
                c_OP_RESTOCK: begin
                    if (!w_cur_exists) begin
                        w_status = c_ST_NO_PROD;
                    end else begin
                        w_wr = 1'b1;
                        if (w_sum[STOCK_W]) begin
                            w_status    = c_ST_OVERFLOW;
                            w_new_stock = c_STOCK_MAX;
                        end else begin
                            w_new_stock = w_sum[STOCK_W-1:0];
                        end
                    end
                end
                default: w_status = c_ST_OK;
            endcase
        end
    end

    // Slot table and sold-out flags commit together on the EXEC->RESP edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_exists[i]    <= 1'b0;
                r_price_tab[i] <= '0;
                r_stock_tab[i] <= '0;
            end
            sold_out <= '0;
        end else if (r_state == c_S_EXEC && w_wr) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (r_code == CODE_W'(i)) begin
                    r_exists[i]    <= w_new_exists;
                    r_price_tab[i] <= w_new_price;
                    r_stock_tab[i] <= w_new_stock;
                    sold_out[i]    <= w_new_exists && (w_new_stock == '0);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_status <= c_ST_OK;
            rsp_price  <= '0;
            rsp_exists <= 1'b0;
            rsp_stock  <= '0;
        end else if (r_state == c_S_EXEC) begin
            rsp_status <= w_status;
            rsp_price  <= w_new_price;
            rsp_exists <= w_new_exists;
            rsp_stock  <= w_new_stock;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_controlador_estoque.sv
`default_nettype none
// ============================================================================
// Module      : tb_controlador_estoque
// Description : Scoreboard bench for controlador_estoque (NUM_SLOTS=10).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_controlador_estoque;

    localparam logic [1:0] c_QUERY = 2'b00, c_VEND = 2'b01, c_WRITE = 2'b10, c_RESTOCK = 2'b11;
    localparam logic [1:0] c_OK = 2'b00, c_NOP = 2'b01, c_SO = 2'b10, c_OVF = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = '0;
    logic [3:0] cmd_code = '0;
    logic [3:0] cmd_price = '0;
    logic [3:0] cmd_qty = '0;
    logic       rsp_valid;
    logic [1:0] rsp_status;
    logic [3:0] rsp_price;
    logic       rsp_exists;
    logic [3:0] rsp_stock;
    logic [9:0] sold_out;

    typedef struct {
        logic [1:0] st;
        logic [3:0] pr;
        logic       ex;
        logic [3:0] sk;
        logic [9:0] so;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    controlador_estoque #(
        .CODE_W(4), .NUM_SLOTS(10), .PRICE_W(4), .STOCK_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_code(cmd_code), .cmd_price(cmd_price), .cmd_qty(cmd_qty),
        .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_price(rsp_price),
        .rsp_exists(rsp_exists), .rsp_stock(rsp_stock), .sold_out(sold_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (q.size() == 0) begin
                check("rsp_spurious", 32'(rsp_valid), 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("rsp_latency", cyc, e.cyc + 2);
                check("rsp_status",  32'(rsp_status), 32'(e.st));
                check("rsp_price",   32'(rsp_price),  32'(e.pr));
                check("rsp_exists",  32'(rsp_exists), 32'(e.ex));
                check("rsp_stock",   32'(rsp_stock),  32'(e.sk));
                check("sold_out",    32'(sold_out),   32'(e.so));
            end
        end
    end

    // Called at a falling edge; returns at the falling edge of the EXEC cycle.
    task automatic send(input logic [1:0] op, input logic [3:0] code, input logic [3:0] price,
                        input logic [3:0] qty, input logic [1:0] est, input logic [3:0] ep,
                        input logic ee, input logic [3:0] es, input logic [9:0] eso);
        int n;
        exp_t e;
        cmd_op = op; cmd_code = code; cmd_price = price; cmd_qty = qty;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 12) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("accept_timeout", 32'(cmd_ready), 32'd1);
        e.st = est; e.pr = ep; e.ex = ee; e.sk = es; e.so = eso; e.cyc = cyc;
        q.push_back(e);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (q.size() == 0) break;
        end
        if (q.size() != 0) check("drain_timeout", q.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        #12;
        check("reset_ready",    32'(cmd_ready),  32'd1);
        check("reset_rsp_vld",  32'(rsp_valid),  32'd0);
        check("reset_sold_out", 32'(sold_out),   32'd0);
        check("reset_rsp_all",  32'({rsp_status, rsp_price, rsp_exists, rsp_stock}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        send(c_WRITE,   4, 8, 2,  c_OK,  8, 1, 2,  10'h000);
        send(c_QUERY,   4, 0, 0,  c_OK,  8, 1, 2,  10'h000);
        send(c_VEND,    4, 0, 0,  c_OK,  8, 1, 1,  10'h000);
        send(c_VEND,    4, 0, 0,  c_OK,  8, 1, 0,  10'h010);
        send(c_VEND,    4, 0, 0,  c_SO,  8, 1, 0,  10'h010);
        send(c_QUERY,   4, 0, 0,  c_SO,  8, 1, 0,  10'h010);
        drain();
        repeat (2) @(negedge clk);
        check("hold_status", 32'(rsp_status), 32'(c_SO));
        check("hold_price",  32'(rsp_price),  32'd8);
        check("idle_no_vld", 32'(rsp_valid),  32'd0);

        send(c_RESTOCK, 4, 0, 3,  c_OK,  8, 1, 3,  10'h000);
        send(c_RESTOCK, 4, 0, 15, c_OVF, 8, 1, 15, 10'h000);
        send(c_RESTOCK, 7, 0, 5,  c_NOP, 0, 0, 0,  10'h000);
        send(c_QUERY,  12, 0, 0,  c_NOP, 0, 0, 0,  10'h000);
        send(c_WRITE,   4, 0, 5,  c_NOP, 0, 0, 0,  10'h000);
        send(c_QUERY,   4, 0, 0,  c_NOP, 0, 0, 0,  10'h000);
        send(c_WRITE,   9, 3, 0,  c_OK,  3, 1, 0,  10'h200);
        send(c_WRITE,   9, 15, 15, c_OK, 15, 1, 15, 10'h000);
        send(c_WRITE,   4, 8, 5,  c_OK,  8, 1, 5,  10'h000);
        drain();

        // Back-to-back: cmd_valid held high, accepts every third cycle.
        cmd_op = c_QUERY; cmd_code = 4; cmd_price = 0; cmd_qty = 0;
        cmd_valid = 1'b1;
        for (int k = 0; k < 9; k++) begin
            check("ready_pattern", 32'(cmd_ready), ((k % 3) == 0) ? 32'd1 : 32'd0);
            if (cmd_ready) begin
                exp_t e;
                e.st = c_OK; e.pr = 8; e.ex = 1; e.sk = 5; e.so = 10'h000; e.cyc = cyc;
                q.push_back(e);
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        drain();

        // Reset during EXEC of a VEND: no response, table cleared.
        cmd_op = c_VEND; cmd_code = 4; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_ready", 32'(cmd_ready),  32'd1);
        check("rst_async_rsp",   32'({rsp_status, rsp_price, rsp_exists, rsp_stock}), 32'd0);
        repeat (2) @(posedge clk);
        check("rst_no_rsp_vld",  32'(rsp_valid),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check("post_rst_ready",  32'(cmd_ready),  32'd1);
        check("post_rst_so",     32'(sold_out),   32'd0);
        send(c_QUERY,   4, 0, 0,  c_NOP, 0, 0, 0,  10'h000);
        send(c_QUERY,   9, 0, 0,  c_NOP, 0, 0, 0,  10'h000);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
